// File: rtl/iccm_window_aligner.sv
// Extracts an OUT_W-bit window from bank read data at a STEP-granular offset.
// MODE 2 windows that run off the end of the word take their upper bits from the next beat.
module iccm_window_aligner #(
    parameter int DATA_W = 12,
    parameter int OUT_W  = 6,
    parameter int STEP   = 2,
    parameter int MODE   = 0,
    localparam int NOFF  = DATA_W / STEP,
    localparam int OFF_W = (NOFF > 1) ? $clog2(NOFF) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_off,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_err,
    output logic [15:0]       span_cnt
);

    typedef enum logic [1:0] {EMPTY, FULL, SPAN_WAIT} state_e;

    state_e              state_q, state_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic                out_err_q, out_err_d;
    logic [DATA_W-1:0]   head_q, head_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [15:0]         span_cnt_q, span_cnt_d;

    logic                accept;
    logic                head_err;
    logic                need_span;
    logic [2*DATA_W-1:0] head_ext;
    logic [OUT_W-1:0]    head_win;
    logic [OUT_W-1:0]    span_win;

    // ext holds {upper source word, current word}; the window is a plain right shift of it.
    function automatic logic [OUT_W-1:0] window_f(input logic [2*DATA_W-1:0] ext,
                                                  input logic [OFF_W-1:0] off);
        logic [2*DATA_W-1:0] sh;
        sh = ext >> (int'(off) * STEP);
        return sh[OUT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
            head_q     <= '0;
            off_q      <= '0;
            span_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
            head_q     <= head_d;
            off_q      <= off_d;
            span_cnt_q <= span_cnt_d;
        end
    end

    always_comb begin
        accept    = in_valid && in_ready;
        head_err  = int'(in_off) >= NOFF;
        need_span = (MODE == 2) && !head_err && !in_last &&
                    (int'(in_off) * STEP + OUT_W > DATA_W);
        // Zero upper word gives zero-fill (MODE 0, MODE 2 last beat); a copy gives rotation.
        head_ext = {{DATA_W{1'b0}}, in_data};
        if (MODE == 1) head_ext[2*DATA_W-1:DATA_W] = in_data;
        head_win = head_err ? '0 : window_f(head_ext, in_off);
        span_win = window_f({in_data, head_q}, off_q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:     if (accept) state_d = need_span ? SPAN_WAIT : FULL;
            FULL:      if (out_ready) state_d = accept ? (need_span ? SPAN_WAIT : FULL) : EMPTY;
            SPAN_WAIT: if (accept) state_d = FULL;
            default:   state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        head_d     = head_q;
        off_d      = off_q;
        span_cnt_d = span_cnt_q;
        if (accept) begin
            if (state_q == SPAN_WAIT) begin
                out_data_d = span_win;
                out_err_d  = 1'b0;
                if (span_cnt_q != 16'hFFFF) span_cnt_d = span_cnt_q + 16'd1;
            end else if (need_span) begin
                head_d = in_data;
                off_d  = in_off;
            end else begin
                out_data_d = head_win;
                out_err_d  = head_err;
            end
        end
    end

    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state_q)
            FULL: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign out_data = out_data_q;
    assign out_err  = out_err_q;
    assign span_cnt = span_cnt_q;

endmodule
